// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: walks a ROWS x COLS frame in row-major order, captures datapath results into memory
//   clk/reset_n          clock, asynchronous active-low reset
//   start                launches a frame (sampled in IDLE only)
//   pix_valid/pix_ready  pixel handshake; row_out/col_out name the pixel being taken
//   res_valid/res_data   datapath result strobe and value
//   wr_en/wr_addr/wr_data  result memory write port, one cycle after each result
//   busy/done            frame in progress / one-cycle end-of-frame pulse
//   err_timeout/err_overflow  sticky per-frame error flags, cleared by the next start
module conv_frame_sequencer #(
    parameter int ROWS      = 28,
    parameter int COLS      = 3,
    parameter int DRAIN_MAX = 16,
    localparam int EXPECTED = (ROWS - 2) * COLS,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS),
    localparam int AW       = $clog2(EXPECTED + 1),
    localparam int DW       = $clog2(DRAIN_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic [RW-1:0] row_out,
    output logic [CW-1:0] col_out,
    input  logic          res_valid,
    input  logic [31:0]   res_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          err_overflow
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [AW-1:0] CNT_FULL   = AW'(EXPECTED);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tout_q, tout_d;
    logic          ovf_q, ovf_d;
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tout_d    = tout_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = FETCH;
                row_d     = '0;
                col_d     = '0;
                cnt_d     = '0;
                drain_d   = '0;
                wr_addr_d = '0;
                tout_d    = 1'b0;
                ovf_d     = 1'b0;
            end
            FETCH: if (pix_valid) begin
                // the final pixel leaves row/col parked on the last index
                if (col_q == COL_LAST) begin
                    if (row_q == ROW_LAST) state_d = DRAIN;
                    else begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end
                end else col_d = col_q + CW'(1);
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                // completion is tested first so it beats a simultaneous timeout
                if (cnt_q == CNT_FULL) state_d = DONE;
                else if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // results are only meaningful while a frame is live; surplus ones are flagged, never written
        if ((state_q == FETCH || state_q == DRAIN) && res_valid) begin
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = res_data;
                cnt_d     = cnt_q + AW'(1);
            end
        end
        busy_d = state_d == FETCH || state_d == DRAIN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            drain_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
            ovf_q     <= ovf_d;
        end
    end
    assign pix_ready    = state_q == FETCH;
    assign row_out      = row_q;
    assign col_out      = col_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = tout_q;
    assign err_overflow = ovf_q;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed and random frames against a schedule-level reference model
module tb_conv_frame_sequencer;
    localparam int ROWS = 28, COLS = 3, DRAIN_MAX = 16;
    localparam int EXP = (ROWS - 2) * COLS, NPIX = ROWS * COLS, MAXC = 600;
    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, pix_valid = 1'b0, res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic        pix_ready, wr_en, busy, done, err_timeout, err_overflow;
    logic [4:0]  row_out;
    logic [1:0]  col_out;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    int          vectors = 0, miscompares = 0;
    bit          pv [MAXC];
    bit          rv [MAXC];
    bit          st [MAXC];
    logic [31:0] dseq [100];
    bit          exp_tout = 1'b0, exp_ovf = 1'b0;

    conv_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .row_out(row_out), .col_out(col_out), .res_valid(res_valid), .res_data(res_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_sched();
        for (int j = 0; j < MAXC; j++) begin
            pv[j] = 1'b0;
            rv[j] = 1'b0;
            st[j] = 1'b0;
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < 100; i++) dseq[i] = $urandom;
    endtask

    task automatic all_pix();
        for (int j = 0; j < MAXC; j++) pv[j] = 1'b1;
    endtask

    task automatic res_run(input int n, input int first, input int gap);
        for (int i = 0; i < n; i++) rv[first + i * gap] = 1'b1;
    endtask

    task automatic rand_sched();
        int p, n, c;
        clear_sched();
        new_data();
        p = int'($urandom_range(40, 100));
        for (int j = 0; j < MAXC; j++) pv[j] = int'($urandom_range(0, 99)) < p;
        n = int'($urandom_range(60, 88));
        c = int'($urandom_range(0, 30));
        for (int i = 0; i < n; i++) begin
            rv[c] = 1'b1;
            c += int'($urandom_range(1, 3));
        end
        for (int j = 0; j < MAXC; j++) st[j] = $urandom_range(0, 19) == 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_row"}, 32'(row_out), 0);
        chk({tag, "_col"}, 32'(col_out), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_tout"}, 32'(err_timeout), 0);
        chk({tag, "_ovf"}, 32'(err_overflow), 0);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_wr_en", 32'(wr_en), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_pix_ready", 32'(pix_ready), 0);
            chk("idle_tout", 32'(err_timeout), 32'(exp_tout));
            chk("idle_ovf", 32'(err_overflow), 32'(exp_ovf));
            start = 1'b0;
            pix_valid = 1'($urandom);
            res_valid = 1'($urandom);
            res_data = $urandom;
        end
    endtask

    // Expected behaviour is derived from the schedule: D = cycle after the NPIX-th accept,
    // the frame completes once the EXP-th result has landed (inside the drain window),
    // otherwise it times out DRAIN_MAX cycles after D. Cycle j is the interval after
    // the j-th clock edge following the start edge.
    task automatic run_frame(input int abort_at);
        int  acc, d, t, r78, k, last_addr;
        bit  tout, wr_pend;
        logic [31:0] pend_data;
        acc = 0;
        d = -1;
        for (int j = 0; j < MAXC && d < 0; j++) begin
            acc += int'(pv[j]);
            if (acc == NPIX) d = j + 1;
        end
        if (d < 0 || d + DRAIN_MAX + 1 >= MAXC) begin
            $display("FAIL schedule: frame does not fit, drain entry %0d", d);
            $fatal(1);
        end
        k = 0;
        r78 = -1;
        for (int j = 0; j < MAXC && r78 < 0; j++) if (rv[j]) begin
            k++;
            if (k == EXP) r78 = j;
        end
        tout = !(r78 >= 0 && r78 < d + DRAIN_MAX - 1);
        t = tout ? d + DRAIN_MAX : ((r78 + 1 > d ? r78 + 1 : d) + 1);
        @(negedge clk);
        chk("pre_busy", 32'(busy), 0);
        chk("pre_done", 32'(done), 0);
        chk("pre_wr_en", 32'(wr_en), 0);
        chk("pre_tout", 32'(err_timeout), 32'(exp_tout));
        chk("pre_ovf", 32'(err_overflow), 32'(exp_ovf));
        start = 1'b1;
        pix_valid = 1'($urandom);
        res_valid = 1'($urandom);
        res_data = $urandom;
        acc = 0;
        k = 0;
        last_addr = 0;
        wr_pend = 1'b0;
        pend_data = '0;
        exp_tout = 1'b0;
        exp_ovf = 1'b0;
        for (int j = 0; j <= t; j++) begin
            @(negedge clk);
            chk("pix_ready", 32'(pix_ready), 32'(j < d));
            chk("busy", 32'(busy), 32'(j < t));
            chk("done", 32'(done), 32'(j == t));
            chk("row", 32'(row_out), (acc < NPIX ? acc : NPIX - 1) / COLS);
            chk("col", 32'(col_out), (acc < NPIX ? acc : NPIX - 1) % COLS);
            chk("wr_en", 32'(wr_en), 32'(wr_pend));
            chk("wr_addr", 32'(wr_addr), last_addr);
            if (wr_pend) chk("wr_data", wr_data, pend_data);
            chk("err_timeout", 32'(err_timeout), 32'(exp_tout));
            chk("err_overflow", 32'(err_overflow), 32'(exp_ovf));
            if (j == abort_at) begin
                #2 reset_n = 1'b0;
                #1 check_zero("async_reset");
                exp_tout = 1'b0;
                exp_ovf = 1'b0;
                start = 1'b0;
                res_valid = 1'b1;
                @(negedge clk);
                check_zero("in_reset");
                reset_n = 1'b1;
                return;
            end
            start = st[j];
            pix_valid = pv[j];
            res_valid = rv[j];
            res_data = rv[j] ? dseq[k] : $urandom;
            if (j < d) acc += int'(pv[j]);
            wr_pend = 1'b0;
            if (rv[j] && j < t) begin
                if (k < EXP) begin
                    wr_pend = 1'b1;
                    last_addr = k;
                    pend_data = dseq[k];
                end else exp_ovf = 1'b1;
            end
            if (rv[j]) k++;
            if (j == t - 1) exp_tout = tout;
        end
    endtask

    initial begin
        #3 check_zero("reset");
        @(negedge clk);
        check_zero("reset_hold");
        reset_n = 1'b1;
        idle(3);
        // nominal: continuous pixels, 78 results
        clear_sched(); new_data(); all_pix(); res_run(EXP, 8, 1);
        run_frame(-1);
        idle(2);
        // stall: pixels every other cycle, same result data
        clear_sched(); for (int j = 0; j < MAXC; j++) pv[j] = (j % 2) == 0; res_run(EXP, 8, 2);
        run_frame(-1);
        idle(2);
        // timeout with 70 results, start pulses during drain are ignored
        clear_sched(); new_data(); all_pix(); res_run(70, 8, 1);
        for (int j = NPIX + 2; j <= NPIX + 4; j++) st[j] = 1'b1;
        run_frame(-1);
        chk("timeout_last_addr", 32'(wr_addr), 69);
        idle(3);
        // overflow: 80 results, flags from the timeout frame clear on this start
        clear_sched(); new_data(); all_pix(); res_run(80, 0, 1);
        run_frame(-1);
        idle(2);
        // completion lands on the last drain cycle: completion wins
        clear_sched(); new_data(); all_pix(); res_run(EXP, NPIX + DRAIN_MAX - 2 - (EXP - 1), 1);
        run_frame(-1);
        idle(1);
        // start held high: next frame launches straight from the IDLE visit
        clear_sched(); new_data(); all_pix(); res_run(EXP, 8, 1);
        for (int j = 0; j < MAXC; j++) st[j] = 1'b1;
        run_frame(-1);
        rand_sched();
        run_frame(-1);
        idle(2);
        // reset mid-FETCH at row 10, then restart from (0,0)
        clear_sched(); new_data(); all_pix(); res_run(EXP, 0, 1);
        run_frame(10 * COLS);
        idle(4);
        rand_sched();
        run_frame(-1);
        for (int f = 0; f < 6; f++) begin
            idle(int'($urandom_range(1, 3)));
            rand_sched();
            run_frame(-1);
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
